// File: rtl/imm_pack_encoder.sv
// imm_pack_encoder: packs a sign-extended immediate into instr[31:7] by ImmSrc
// type (I/S/B/J), merging in the non-immediate bits, and queues the result in
// a small output FIFO with valid/ready on both sides.
// Optional feature macro: IMM_RANGE_CHECK_EN enables the representability
// check, per-entry error storage and the saturating err_count.
module imm_pack_encoder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    in_src,
  input  logic [31:0]                   in_imm,
  input  logic [24:0]                   in_rest,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [24:0]                   out_field,
  output logic                          out_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              err_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef enum logic [1:0] {SrcI = 2'd0, SrcS = 2'd1, SrcB = 2'd2, SrcJ = 2'd3} src_e;

  logic [24:0]   enc_field;
  logic          push, pop;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [24:0]   field_mem [FIFO_DEPTH];

  // Scatter immediate bits into the instruction field; the rest passes through.
  always_comb begin
    enc_field = in_rest;
    case (src_e'(in_src))
      SrcI: enc_field[24:13] = in_imm[11:0];
      SrcS: begin
        enc_field[24:18] = in_imm[11:5];
        enc_field[4:0]   = in_imm[4:0];
      end
      SrcB: begin
        enc_field[24]    = in_imm[12];
        enc_field[23:18] = in_imm[10:5];
        enc_field[4:1]   = in_imm[4:1];
        enc_field[0]     = in_imm[11];
      end
      default: begin
        enc_field[24]    = in_imm[20];
        enc_field[23:14] = in_imm[10:1];
        enc_field[13]    = in_imm[11];
        enc_field[12:5]  = in_imm[19:12];
      end
    endcase
  end

  assign in_ready   = (level_q < LW'(FIFO_DEPTH));
  assign out_valid  = (level_q != '0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign fifo_level = level_q;
  // Gate with out_valid so stale storage never shows after reset or drain.
  assign out_field  = out_valid ? field_mem[rd_ptr_q] : '0;

  // Pointer and occupancy next-state; pointers wrap modulo the power-of-2 depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  // FIFO control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // FIFO storage; contents need no reset because the head is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      field_mem[wr_ptr_q] <= enc_field;
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  logic             enc_err;
  logic             err_mem [FIFO_DEPTH];
  logic [CNT_W-1:0] err_count_q, err_count_d;

  // Representability: upper bits must be pure sign extension; B/J must be even.
  always_comb begin
    case (src_e'(in_src))
      SrcI, SrcS: enc_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      SrcB:       enc_err = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
      default:    enc_err = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
    endcase
  end

  // Saturating count of erroneous words accepted into the FIFO.
  always_comb begin
    err_count_d = err_count_q;
    if (push && enc_err && (err_count_q != '1)) begin
      err_count_d = err_count_q + CNT_W'(1);
    end
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  // Per-entry error flag storage, written alongside the field.
  always_ff @(posedge clk) begin
    if (push) begin
      err_mem[wr_ptr_q] <= enc_err;
    end
  end

  assign out_err   = out_valid ? err_mem[rd_ptr_q] : 1'b0;
  assign err_count = err_count_q;
`else
  // Upper immediate bits only feed the range check.
  logic imm_unused;
  assign imm_unused = ^in_imm[31:21];
  assign out_err    = 1'b0;
  assign err_count  = '0;
`endif

endmodule

// File: tb/tb_imm_pack_encoder.sv
// Self-checking bench for imm_pack_encoder: table-driven packing vectors plus
// directed FIFO sequences (fill/backpressure, push+pop, reset mid-drain).
// Expected error flags depend on IMM_RANGE_CHECK_EN.
module tb_imm_pack_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_src;
  logic [31:0] in_imm;
  logic [24:0] in_rest;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_field;
  logic        out_err;
  logic [2:0]  fifo_level;
  logic [15:0] err_count;

  int n_cmp = 0;
  int n_bad = 0;

  imm_pack_encoder #(
    .FIFO_DEPTH(4),
    .CNT_W     (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_src    (in_src),
    .in_imm    (in_imm),
    .in_rest   (in_rest),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_field (out_field),
    .out_err   (out_err),
    .fifo_level(fifo_level),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  src;
    logic [31:0] imm;
    logic [24:0] rest;
    logic [24:0] field;
    logic        err;   // error flag when the range check is built in
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

`ifdef IMM_RANGE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one I-type word (rest=0) on the next edge; caller sets out_ready.
  task automatic drive_i(input logic [31:0] imm);
    @(negedge clk);
    in_valid = 1'b1;
    in_src   = 2'd0;
    in_imm   = imm;
    in_rest  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int exp_cnt;

  initial begin
    vecs[0]  = '{2'd0, 32'hFFFF_FFFF, 25'h0,       25'h1FFE000, 1'b0};
    vecs[1]  = '{2'd1, 32'h0000_07FF, 25'h0,       25'h0FC001F, 1'b0};
    vecs[2]  = '{2'd2, 32'h0000_0800, 25'h0,       25'h0000001, 1'b0};
    vecs[3]  = '{2'd2, 32'h0000_0801, 25'h0,       25'h0000001, 1'b1};
    vecs[4]  = '{2'd3, 32'hFFFF_FFFE, 25'h1F,      25'h1FFFFFF, 1'b0};
    vecs[5]  = '{2'd3, 32'h0010_0000, 25'h0,       25'h1000000, 1'b1};
    vecs[6]  = '{2'd0, 32'h0000_0800, 25'h0,       25'h1000000, 1'b1};
    vecs[7]  = '{2'd0, 32'h0000_0123, 25'h1FFFFFF, 25'h0247FFF, 1'b0};
    vecs[8]  = '{2'd1, 32'hFFFF_F800, 25'h1FFFFFF, 25'h103FFE0, 1'b0};
    vecs[9]  = '{2'd2, 32'hFFFF_F000, 25'h0,       25'h1000000, 1'b0};
    vecs[10] = '{2'd1, 32'h0000_0800, 25'h0,       25'h1000000, 1'b1};
    vecs[11] = '{2'd3, 32'h0000_0002, 25'h0,       25'h0004000, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_src = '0; in_imm = '0; in_rest = '0;
    do_reset();

    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_level",     32'(fifo_level), 32'd0);
    chk("rst_field",     32'(out_field), 32'd0);
    chk("rst_err",       32'(out_err),   32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);

    // Table: each word pushed into an empty FIFO appears right after the edge.
    exp_cnt   = 0;
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_src   = vecs[i].src;
      in_imm   = vecs[i].imm;
      in_rest  = vecs[i].rest;
      step();
      if (CHK && vecs[i].err) exp_cnt++;
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_field", i), 32'(out_field), 32'(vecs[i].field));
      chk($sformatf("v%0d_err", i),   32'(out_err),   32'(CHK & vecs[i].err));
      chk($sformatf("v%0d_level", i), 32'(fifo_level), 32'd1);
      chk($sformatf("v%0d_ecnt", i),  32'(err_count), 32'(exp_cnt));
      @(negedge clk);
      in_valid = 1'b0;
      step();
      chk($sformatf("v%0d_drained", i), 32'(fifo_level), 32'd0);
    end

    // Backpressure: offer 5 words with out_ready low; only 4 fit.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive_i(32'(k + 1));
      step();
      if (k == 3) chk("fill4_in_ready", 32'(in_ready), 32'd0);
    end
    chk("full_level",    32'(fifo_level), 32'd4);
    chk("full_in_ready", 32'(in_ready),   32'd0);
    chk("hold_head",     32'(out_field),  32'h2000);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d_field", k), 32'(out_field), 32'((k + 1) << 13));
      step();
    end
    chk("drain_level", 32'(fifo_level), 32'd0);
    chk("drain_valid", 32'(out_valid),  32'd0);

    // Simultaneous push and pop keeps the level and the order.
    @(negedge clk);
    out_ready = 1'b0;
    drive_i(32'h10); step();
    drive_i(32'h20); step();
    drive_i(32'h30);
    out_ready = 1'b1;
    step();
    chk("pp_level", 32'(fifo_level), 32'd2);
    chk("pp_head",  32'(out_field),  32'h0040000);
    @(negedge clk);
    in_valid = 1'b0;
    step();
    chk("pp_next", 32'(out_field), 32'h0060000);
    step();
    chk("pp_empty", 32'(fifo_level), 32'd0);

    // Reset in the middle of a drain discards the remaining words.
    @(negedge clk);
    out_ready = 1'b0;
    drive_i(32'h800); step();
    drive_i(32'h1);   step();
    drive_i(32'h2);   step();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("mid_level", 32'(fifo_level), 32'd2);
    chk("mid_ecnt",  32'(err_count),  32'(CHK ? 1 : 0));
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("mrst_valid",    32'(out_valid),  32'd0);
    chk("mrst_level",    32'(fifo_level), 32'd0);
    chk("mrst_in_ready", 32'(in_ready),   32'd1);
    chk("mrst_field",    32'(out_field),  32'd0);
    chk("mrst_err",      32'(out_err),    32'd0);
    chk("mrst_ecnt",     32'(err_count),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
